// File: rtl/sat_engine_pkg.sv
// sat_engine_pkg: value encodings, implied-bit position and scan FSM states
package sat_engine_pkg;
    localparam logic [1:0] VAL_FREE     = 2'b00;
    localparam logic [1:0] VAL_TRUE     = 2'b10;
    localparam logic [1:0] VAL_FALSE    = 2'b01;
    localparam logic [1:0] VAL_CONFLICT = 2'b11;
    localparam int         IMPLIED_BIT  = 0;
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} scan_state_t;
endpackage

// File: rtl/var_state_bank_if.sv
// var_state_bank_if: clause/controller traffic of one variable bank
interface var_state_bank_if #(
    parameter int NUM_VARS  = 8,
    parameter int WIDTH_LVL = 16,
    parameter int WIDTH_IDX = $clog2(NUM_VARS)
);
    logic [3*NUM_VARS-1:0]             value_i;
    logic [3*NUM_VARS-1:0]             value_o;
    logic [WIDTH_LVL*NUM_VARS-1:0]     lvl_i;
    logic [WIDTH_LVL*NUM_VARS-1:0]     lvl_o;
    logic                              dec_valid_i;
    logic [WIDTH_IDX-1:0]              dec_idx_i;
    logic [WIDTH_LVL-1:0]              cur_lvl_i;
    logic                              imply_i;
    logic [NUM_VARS-1:0]               find_imply_o;
    logic                              conflict_o;
    logic                              analyze_i;
    logic [2*NUM_VARS-1:0]             learnt_o;
    logic                              scan_start_i;
    logic                              scan_done_o;
    logic [WIDTH_LVL-1:0]              max_lvl_o;
    logic [WIDTH_LVL-1:0]              bkt_lvl_o;
    logic                              bkt_i;
    logic [WIDTH_LVL-1:0]              bkt_lvl_i;
    logic                              wr_states_i;
    logic [(3+WIDTH_LVL)*NUM_VARS-1:0] states_i;
    logic [(3+WIDTH_LVL)*NUM_VARS-1:0] states_o;
    modport master (
        output value_i, lvl_i, dec_valid_i, dec_idx_i, cur_lvl_i, imply_i, analyze_i,
               scan_start_i, bkt_i, bkt_lvl_i, wr_states_i, states_i,
        input  value_o, lvl_o, find_imply_o, conflict_o, learnt_o, scan_done_o,
               max_lvl_o, bkt_lvl_o, states_o
    );
    modport slave (
        input  value_i, lvl_i, dec_valid_i, dec_idx_i, cur_lvl_i, imply_i, analyze_i,
               scan_start_i, bkt_i, bkt_lvl_i, wr_states_i, states_i,
        output value_o, lvl_o, find_imply_o, conflict_o, learnt_o, scan_done_o,
               max_lvl_o, bkt_lvl_o, states_o
    );
endinterface

// File: rtl/var_state_bank_cell.sv
// var_state_cell: one variable's value, level, saved phase, pre-analysis snapshot and learnt literal
module var_state_cell
    import sat_engine_pkg::*;
#(
    parameter int WIDTH_LVL  = 16,
    parameter int PHASE_SAVE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_dec,
    input  logic [WIDTH_LVL-1:0] i_cur_lvl,
    input  logic                 i_imply,
    input  logic [2:0]           i_value,
    input  logic [WIDTH_LVL-1:0] i_lvl,
    input  logic                 i_analyze,
    input  logic                 i_bkt,
    input  logic [WIDTH_LVL-1:0] i_bkt_lvl,
    input  logic                 i_wr,
    input  logic [2:0]           i_state_value,
    input  logic [WIDTH_LVL-1:0] i_state_lvl,
    output logic [2:0]           o_value,
    output logic [WIDTH_LVL-1:0] o_lvl,
    output logic [1:0]           o_learnt
);
    logic [2:0]           r_value, r_saved_val, w_value;
    logic [WIDTH_LVL-1:0] r_lvl, w_lvl;
    logic [1:0]           r_learnt, w_learnt;
    logic                 r_phase, w_dec_phase, w_marked, w_capture;

    always_comb begin
        w_dec_phase = (PHASE_SAVE != 0) ? r_phase : 1'b1;
        w_marked    = r_value[2:1] == VAL_CONFLICT;
        w_value     = r_value;
        w_lvl       = r_lvl;
        if (i_wr) begin
            w_value = i_state_value;
            w_lvl   = i_state_lvl;
        end else if (i_dec) begin
            w_value = {w_dec_phase, ~w_dec_phase, 1'b0};
            w_lvl   = i_cur_lvl;
        end else if (i_imply && i_value[IMPLIED_BIT]) begin
            w_value = i_value;
            w_lvl   = i_lvl;
        end else if (i_analyze && i_value[2:1] == VAL_CONFLICT)
            w_value = {VAL_CONFLICT, r_value[IMPLIED_BIT]};  // keep implied bit: it tells decisions apart
        else if (i_bkt && r_lvl > i_bkt_lvl)
            w_value = '0;
        else if (i_bkt && r_learnt != 2'b00 && r_lvl == i_bkt_lvl)
            w_value = {~r_saved_val[2:1], r_saved_val[IMPLIED_BIT]};
        w_capture = w_marked && (r_lvl != i_cur_lvl || !r_value[IMPLIED_BIT] || !i_value[IMPLIED_BIT]);
        w_learnt  = w_capture ? ~r_saved_val[2:1] : (w_marked || i_analyze) ? r_learnt : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_value     <= 3'b111;
            r_lvl       <= '0;
            r_phase     <= 1'b1;
            r_saved_val <= '0;
            r_learnt    <= '0;
        end else begin
            r_value     <= w_value;
            r_lvl       <= w_lvl;
            r_phase     <= (w_value[2:1] == VAL_TRUE) ? 1'b1 : (w_value[2:1] == VAL_FALSE) ? 1'b0 : r_phase;
            r_saved_val <= i_analyze ? r_saved_val : r_value;
            r_learnt    <= w_learnt;
        end
    end

    assign o_value  = r_value;
    assign o_lvl    = r_lvl;
    assign o_learnt = r_learnt;
endmodule

// File: rtl/var_state_bank.sv
// var_state_bank: assignment state of all variables of one bin, with
// decide/imply/backtrack/load, learnt-literal capture and a max/backjump level scan
module var_state_bank
    import sat_engine_pkg::*;
#(
    parameter int NUM_VARS   = 8,
    parameter int WIDTH_LVL  = 16,
    parameter int PHASE_SAVE = 1,
    parameter int WIDTH_IDX  = $clog2(NUM_VARS)
) (
    input logic             clk,
    input logic             rst,
    var_state_bank_if.slave bus
);
    localparam int SW = 3 + WIDTH_LVL;

    logic [WIDTH_LVL-1:0] w_lvl_a [NUM_VARS];
    logic [1:0]           w_lrn_a [NUM_VARS];
    logic [NUM_VARS-1:0]  w_conf;

    for (genvar k = 0; k < NUM_VARS; k++) begin : g_var
        logic [2:0]           w_val;
        logic [WIDTH_LVL-1:0] w_l;
        logic [1:0]           w_lrn;
        var_state_cell #(.WIDTH_LVL(WIDTH_LVL), .PHASE_SAVE(PHASE_SAVE)) u_cell (
            .clk           (clk),
            .rst           (rst),
            .i_dec         (bus.dec_valid_i && bus.dec_idx_i == WIDTH_IDX'(k)),
            .i_cur_lvl     (bus.cur_lvl_i),
            .i_imply       (bus.imply_i),
            .i_value       (bus.value_i[3*k +: 3]),
            .i_lvl         (bus.lvl_i[WIDTH_LVL*k +: WIDTH_LVL]),
            .i_analyze     (bus.analyze_i),
            .i_bkt         (bus.bkt_i),
            .i_bkt_lvl     (bus.bkt_lvl_i),
            .i_wr          (bus.wr_states_i),
            .i_state_value (bus.states_i[SW*k+WIDTH_LVL +: 3]),
            .i_state_lvl   (bus.states_i[SW*k +: WIDTH_LVL]),
            .o_value       (w_val),
            .o_lvl         (w_l),
            .o_learnt      (w_lrn)
        );
        assign bus.value_o[3*k +: 3]                 = w_val;
        assign bus.lvl_o[WIDTH_LVL*k +: WIDTH_LVL]   = w_l;
        assign bus.learnt_o[2*k +: 2]                = w_lrn;
        assign bus.states_o[SW*k +: SW]              = {w_val, w_l};
        assign bus.find_imply_o[k]                   = bus.value_i[3*k+IMPLIED_BIT] && w_val[2:1] == VAL_FREE;
        assign w_conf[k]  = w_val[2:1] == VAL_CONFLICT || bus.value_i[3*k+1 +: 2] == VAL_CONFLICT;
        assign w_lvl_a[k] = w_l;
        assign w_lrn_a[k] = w_lrn;
    end

    assign bus.conflict_o = |w_conf;

    scan_state_t          r_state, w_state;
    logic [WIDTH_IDX-1:0] r_idx;
    logic [WIDTH_LVL-1:0] r_max, r_second, r_max_o, r_bkt_o, w_max, w_second, w_cl;
    logic                 w_last, w_hit, w_up;

    always_ff @(posedge clk) r_state <= !rst ? S_IDLE : w_state;

    always_comb begin
        w_last   = r_idx == WIDTH_IDX'(NUM_VARS - 1);
        w_state  = (r_state == S_IDLE) ? (bus.scan_start_i ? S_SCAN : S_IDLE)
                 : (r_state == S_SCAN) ? (w_last ? S_DONE : S_SCAN) : S_IDLE;
        w_cl     = w_lvl_a[r_idx];
        w_hit    = w_lrn_a[r_idx] != 2'b00;
        w_up     = w_hit && w_cl > r_max;
        w_max    = w_up ? w_cl : r_max;
        w_second = w_up ? r_max : (w_hit && w_cl < r_max && w_cl > r_second) ? w_cl : r_second;
    end

    // results are latched on the last visit so they are valid alongside the done pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idx    <= '0;
            r_max    <= '0;
            r_second <= '0;
            r_max_o  <= '0;
            r_bkt_o  <= '0;
        end else if (r_state == S_IDLE && bus.scan_start_i) begin
            r_idx    <= '0;
            r_max    <= '0;
            r_second <= '0;
        end else if (r_state == S_SCAN) begin
            r_idx    <= r_idx + 1'b1;
            r_max    <= w_max;
            r_second <= w_second;
            if (w_last) begin
                r_max_o <= w_max;
                r_bkt_o <= w_second;
            end
        end
    end

    assign bus.scan_done_o = r_state == S_DONE;
    assign bus.max_lvl_o   = r_max_o;
    assign bus.bkt_lvl_o   = r_bkt_o;
endmodule

// File: tb/tb_var_state_bank.sv
// tb_var_state_bank: directed scenarios plus randomized traffic against a
// per-variable rule model of the bank
module tb_var_state_bank;
    localparam int N  = 8;
    localparam int W  = 16;
    localparam int SW = 3 + W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    var_state_bank_if #(.NUM_VARS(N), .WIDTH_LVL(W)) bus ();
    var_state_bank #(.NUM_VARS(N), .WIDTH_LVL(W), .PHASE_SAVE(1)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [2:0]   m_val [N];
    logic [W-1:0] m_lvl [N];
    logic         m_ph  [N];
    logic [2:0]   m_sv  [N];
    logic [1:0]   m_lrn [N];

    // advance the model by one clock using the inputs currently driven, then step the DUT
    task automatic tick();
        logic [2:0]   nv [N];
        logic [W-1:0] nl [N];
        logic         np [N];
        logic [2:0]   ns [N];
        logic [1:0]   nr [N];
        for (int k = 0; k < N; k++) begin
            logic [2:0]    vi;
            logic [SW-1:0] st;
            logic          marked, reason_elsewhere;
            vi = bus.value_i[3*k +: 3];
            st = bus.states_i[SW*k +: SW];
            marked = m_val[k][2:1] == 2'b11;
            nv[k] = m_val[k];
            nl[k] = m_lvl[k];
            if (bus.wr_states_i) begin
                nv[k] = st[SW-1 -: 3];
                nl[k] = st[W-1:0];
            end else if (bus.dec_valid_i && int'(bus.dec_idx_i) == k) begin
                nv[k] = m_ph[k] ? 3'b100 : 3'b010;
                nl[k] = bus.cur_lvl_i;
            end else if (bus.imply_i && vi[0]) begin
                nv[k] = vi;
                nl[k] = bus.lvl_i[W*k +: W];
            end else if (bus.analyze_i && vi[2:1] == 2'b11)
                nv[k] = {2'b11, m_val[k][0]};
            else if (bus.bkt_i && m_lvl[k] > bus.bkt_lvl_i)
                nv[k] = 3'b000;
            else if (bus.bkt_i && m_lrn[k] != 2'b00 && m_lvl[k] == bus.bkt_lvl_i)
                nv[k] = {~m_sv[k][2:1], m_sv[k][0]};
            np[k] = (nv[k][2:1] == 2'b10) ? 1'b1 : (nv[k][2:1] == 2'b01) ? 1'b0 : m_ph[k];
            ns[k] = bus.analyze_i ? m_sv[k] : m_val[k];
            reason_elsewhere = m_lvl[k] != bus.cur_lvl_i || !m_val[k][0] || !vi[0];
            if (marked) nr[k] = reason_elsewhere ? ~m_sv[k][2:1] : m_lrn[k];
            else nr[k] = bus.analyze_i ? m_lrn[k] : 2'b00;
        end
        @(posedge clk);
        for (int k = 0; k < N; k++) begin
            m_val[k] = !rst ? 3'b111 : nv[k];
            m_lvl[k] = !rst ? '0 : nl[k];
            m_ph[k]  = !rst ? 1'b1 : np[k];
            m_sv[k]  = !rst ? 3'b000 : ns[k];
            m_lrn[k] = !rst ? 2'b00 : nr[k];
        end
        #1;
    endtask

    task automatic test_reset();
        bus.value_i = '0; bus.lvl_i = '0; bus.dec_valid_i = 0; bus.dec_idx_i = '0;
        bus.cur_lvl_i = '0; bus.imply_i = 0; bus.analyze_i = 0; bus.scan_start_i = 0;
        bus.bkt_i = 0; bus.bkt_lvl_i = '0; bus.wr_states_i = 0; bus.states_i = '0;
        rst = 0;
        tick(); tick();
        n_total++; if (bus.value_o !== {N{3'b111}}) $display("FAIL reset_value got %h want %h", bus.value_o, {N{3'b111}}); else n_pass++;
        n_total++; if (bus.lvl_o !== '0) $display("FAIL reset_lvl got %h want 0", bus.lvl_o); else n_pass++;
        n_total++; if (bus.scan_done_o !== 1'b0) $display("FAIL reset_done got %b want 0", bus.scan_done_o); else n_pass++;
        n_total++; if (bus.learnt_o !== '0) $display("FAIL reset_learnt got %h want 0", bus.learnt_o); else n_pass++;
        n_total++; if (bus.max_lvl_o !== '0 || bus.bkt_lvl_o !== '0) $display("FAIL reset_scan_lvls got %0d/%0d want 0/0", bus.max_lvl_o, bus.bkt_lvl_o); else n_pass++;
        rst = 1;
        tick();
    endtask

    task automatic test_decide_phase();
        bus.states_i = '0; bus.wr_states_i = 1; tick(); bus.wr_states_i = 0;
        bus.value_i[3*3 +: 3] = 3'b011; bus.lvl_i[W*3 +: W] = 1; bus.imply_i = 1; tick();
        bus.imply_i = 0; bus.value_i = '0; bus.lvl_i = '0;
        n_total++; if (bus.value_o[9 +: 3] !== 3'b011 || bus.lvl_o[W*3 +: W] !== 16'd1) $display("FAIL imply_false got %b/%0d want 011/1", bus.value_o[9 +: 3], bus.lvl_o[W*3 +: W]); else n_pass++;
        bus.bkt_i = 1; bus.bkt_lvl_i = 0; tick(); bus.bkt_i = 0;
        n_total++; if (bus.value_o[9 +: 3] !== 3'b000) $display("FAIL bkt_clear got %b want 000", bus.value_o[9 +: 3]); else n_pass++;
        bus.dec_valid_i = 1; bus.dec_idx_i = 3; bus.cur_lvl_i = 2; tick();
        n_total++; if (bus.value_o[9 +: 3] !== 3'b010 || bus.lvl_o[W*3 +: W] !== 16'd2) $display("FAIL decide_saved_phase got %b/%0d want 010/2", bus.value_o[9 +: 3], bus.lvl_o[W*3 +: W]); else n_pass++;
        bus.dec_idx_i = 5; tick();
        n_total++; if (bus.value_o[15 +: 3] !== 3'b100) $display("FAIL decide_default_phase got %b want 100", bus.value_o[15 +: 3]); else n_pass++;
        bus.dec_idx_i = 6; bus.imply_i = 1; bus.value_i[3*6 +: 3] = 3'b011; bus.lvl_i[W*6 +: W] = 9; tick();
        n_total++; if (bus.value_o[18 +: 3] !== 3'b100 || bus.lvl_o[W*6 +: W] !== 16'd2) $display("FAIL decide_beats_imply got %b/%0d want 100/2", bus.value_o[18 +: 3], bus.lvl_o[W*6 +: W]); else n_pass++;
        bus.dec_valid_i = 0; bus.imply_i = 0; bus.value_i = '0; bus.lvl_i = '0;
    endtask

    task automatic test_imply_conflict();
        bus.value_i[3*1 +: 3] = 3'b101; bus.lvl_i[W*1 +: W] = 2; bus.imply_i = 1; tick();
        bus.imply_i = 0; bus.value_i = '0; bus.lvl_i = '0; #1;
        n_total++; if (bus.value_o[3 +: 3] !== 3'b101 || bus.lvl_o[W +: W] !== 16'd2) $display("FAIL imply_true got %b/%0d want 101/2", bus.value_o[3 +: 3], bus.lvl_o[W +: W]); else n_pass++;
        n_total++; if (bus.conflict_o !== 1'b0) $display("FAIL no_conflict got %b want 0", bus.conflict_o); else n_pass++;
        bus.value_i[3*1 +: 3] = 3'b111; #1;
        n_total++; if (bus.conflict_o !== 1'b1) $display("FAIL input_conflict got %b want 1", bus.conflict_o); else n_pass++;
        bus.value_i = '0;
        tick();
    endtask

    task automatic test_learnt_scan();
        bus.states_i = '0;
        bus.states_i[SW*0 +: SW] = {3'b101, 16'd1};
        bus.states_i[SW*2 +: SW] = {3'b011, 16'd3};
        bus.states_i[SW*4 +: SW] = {3'b100, 16'd3};
        bus.wr_states_i = 1; tick(); bus.wr_states_i = 0;
        tick();
        bus.analyze_i = 1; bus.cur_lvl_i = 3;
        bus.value_i = '0; bus.value_i[0 +: 3] = 3'b111; bus.value_i[6 +: 3] = 3'b111; bus.value_i[12 +: 3] = 3'b111;
        tick(); tick();
        n_total++; if (bus.value_o[1 +: 2] !== 2'b11 || bus.value_o[7 +: 2] !== 2'b11 || bus.value_o[13 +: 2] !== 2'b11) $display("FAIL analyze_mark got %b want conflict-marked vars 0,2,4", bus.value_o); else n_pass++;
        n_total++; if (bus.learnt_o !== 16'h0101) $display("FAIL learnt_capture got %h want 0101", bus.learnt_o); else n_pass++;
        bus.scan_start_i = 1; tick(); bus.scan_start_i = 0;
        for (int c = 1; c <= N + 3; c++) begin
            n_total++; if (bus.scan_done_o !== (c == N + 1)) $display("FAIL scan_done_timing cycle %0d got %b want %b", c, bus.scan_done_o, c == N + 1); else n_pass++;
            if (c == N + 1) begin
                n_total++; if (bus.max_lvl_o !== 16'd3 || bus.bkt_lvl_o !== 16'd1) $display("FAIL scan_levels got %0d/%0d want 3/1", bus.max_lvl_o, bus.bkt_lvl_o); else n_pass++;
            end
            bus.scan_start_i = (c == 3);
            tick();
        end
        bus.scan_start_i = 0;
    endtask

    task automatic test_backtrack();
        bus.value_i = '0; bus.bkt_i = 1; bus.bkt_lvl_i = 1; tick(); bus.bkt_i = 0;
        n_total++; if (bus.value_o[0 +: 3] !== 3'b011 || bus.lvl_o[0 +: W] !== 16'd1) $display("FAIL bkt_flip got %b/%0d want 011/1", bus.value_o[0 +: 3], bus.lvl_o[0 +: W]); else n_pass++;
        n_total++; if (bus.value_o[6 +: 3] !== 3'b000 || bus.value_o[12 +: 3] !== 3'b000) $display("FAIL bkt_clear_above got %b/%b want 000/000", bus.value_o[6 +: 3], bus.value_o[12 +: 3]); else n_pass++;
        bus.analyze_i = 0; tick(); tick();
    endtask

    task automatic test_scan_edges();
        n_total++; if (bus.learnt_o !== '0) $display("FAIL learnt_release got %h want 0", bus.learnt_o); else n_pass++;
        bus.scan_start_i = 1; tick(); bus.scan_start_i = 0;
        for (int c = 1; c <= N; c++) tick();
        n_total++; if (bus.scan_done_o !== 1'b1 || bus.max_lvl_o !== '0 || bus.bkt_lvl_o !== '0) $display("FAIL scan_empty got done=%b %0d/%0d want 1 0/0", bus.scan_done_o, bus.max_lvl_o, bus.bkt_lvl_o); else n_pass++;
        tick();
        bus.scan_start_i = 1; tick(); bus.scan_start_i = 0;
        tick(); tick();
        rst = 0; tick(); rst = 1;
        for (int c = 0; c < N + 3; c++) begin
            n_total++; if (bus.scan_done_o !== 1'b0) $display("FAIL reset_abort cycle %0d got done=%b want 0", c, bus.scan_done_o); else n_pass++;
            tick();
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 400; it++) begin
            logic [3*N-1:0] e_val;
            logic [W*N-1:0] e_lvl;
            logic [2*N-1:0] e_lrn;
            logic           e_conf;
            bus.wr_states_i = $urandom_range(0, 15) == 0;
            for (int k = 0; k < N; k++) begin
                bus.states_i[SW*k +: SW] = {3'($urandom), 16'($urandom_range(0, 7))};
                bus.lvl_i[W*k +: W] = 16'($urandom_range(0, 7));
            end
            bus.dec_valid_i = $urandom_range(0, 3) == 0;
            bus.dec_idx_i   = 3'($urandom_range(0, N - 1));
            bus.cur_lvl_i   = 16'($urandom_range(0, 7));
            bus.imply_i     = 1'($urandom_range(0, 1));
            bus.value_i     = 24'($urandom);
            bus.analyze_i   = $urandom_range(0, 3) == 0;
            bus.bkt_i       = $urandom_range(0, 5) == 0;
            bus.bkt_lvl_i   = 16'($urandom_range(0, 7));
            tick();
            e_conf = 1'b0;
            for (int k = 0; k < N; k++) begin
                e_val[3*k +: 3] = m_val[k];
                e_lvl[W*k +: W] = m_lvl[k];
                e_lrn[2*k +: 2] = m_lrn[k];
                e_conf |= m_val[k][2:1] == 2'b11 || bus.value_i[3*k+1 +: 2] == 2'b11;
            end
            n_total++; if (bus.value_o !== e_val) $display("FAIL rand_value it %0d got %h want %h", it, bus.value_o, e_val); else n_pass++;
            n_total++; if (bus.lvl_o !== e_lvl) $display("FAIL rand_lvl it %0d got %h want %h", it, bus.lvl_o, e_lvl); else n_pass++;
            n_total++; if (bus.learnt_o !== e_lrn) $display("FAIL rand_learnt it %0d got %h want %h", it, bus.learnt_o, e_lrn); else n_pass++;
            n_total++; if (bus.conflict_o !== e_conf) $display("FAIL rand_conflict it %0d got %b want %b", it, bus.conflict_o, e_conf); else n_pass++;
        end
        bus.wr_states_i = 0; bus.dec_valid_i = 0; bus.imply_i = 0; bus.analyze_i = 0; bus.bkt_i = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_decide_phase();
        test_imply_conflict();
        test_learnt_scan();
        test_backtrack();
        test_scan_edges();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/var_state_bank.md
# var_state_bank

Holds the assignment state (value, decision level, saved phase) of all `NUM_VARS` variables of one Sat Engine bin in a single block, replacing the per-variable state instances. It adds three behaviours: indexed decisions with optional phase saving, learnt-literal capture across the bank, and a sequential scan that reports both the highest and the second-highest (backjump) level of the learnt clause. It sits between the clause array (imply/conflict traffic) and the engine controller (decide/analyze/backtrack/load).

## Interface

**Parameters**
- `NUM_VARS`, default 8: variables per bin.
- `WIDTH_LVL`, default 16: decision-level width.
- `PHASE_SAVE`, default 1: 1 = a decision takes the saved phase; 0 = a decision always assigns true.
- `WIDTH_IDX`, default `$clog2(NUM_VARS)`: variable index width.

**Ports**
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `value_i` in 3·N: proposed values from clauses, var k at bits [3k+2:3k].
- `value_o` out 3·N: current values.
- `lvl_i` in W·N: levels accompanying implications.
- `lvl_o` out W·N: current levels.
- `dec_valid_i` in 1: decide variable `dec_idx_i`.
- `dec_idx_i` in WIDTH_IDX: index of the variable to decide.
- `cur_lvl_i` in W: current decision level.
- `imply_i` in 1: apply implications.
- `find_imply_o` out N: per-variable implied flag.
- `conflict_o` out 1: any variable has value[2:1] = 11, on either input or register.
- `analyze_i` in 1: conflict-analysis phase.
- `learnt_o` out 2·N: learnt literal per variable; 00 = variable absent from the clause.
- `scan_start_i` in 1: start the level scan.
- `scan_done_o` out 1: one-cycle pulse when the scan finishes.
- `max_lvl_o` out W: highest level in the learnt clause.
- `bkt_lvl_o` out W: second-highest distinct level in the learnt clause.
- `bkt_i` in 1: apply backtrack.
- `bkt_lvl_i` in W: target level of the backtrack.
- `wr_states_i` in 1: load states.
- `states_i` in N·(3+W): states to load, per variable {value, lvl}.
- `states_o` out N·(3+W): current states, per variable {value, lvl}.

## Operation

**Value encoding:** [2:1] = 10 true, 01 false, 00 free, 11 conflict-marked; bit 0 = implied.

**Per-variable value priority** (first match wins):
1. Load.
2. Decision, when `dec_valid_i` and the index matches: value = {phase, ~phase, 0}, lvl = `cur_lvl_i`.
3. Implication, when `imply_i` and `value_i[0]`: take `value_i` and `lvl_i`.
4. Analyze mark, when `analyze_i` and `value_i[2:1]` = 11.
5. Backtrack clear, when `bkt_i` and lvl > `bkt_lvl_i`: value = 000. The saved phase is the phase before clearing.
6. Flip, when `bkt_i`, learnt ≠ 00 and lvl = `bkt_lvl_i`: value = {~saved[2:1], saved[0]}.
7. Otherwise hold.

**Phase:**
- `phase` = saved phase when `PHASE_SAVE` = 1, else 1.
- Saved phase resets to 1.
- Saved phase updates whenever value[2:1] becomes 10 or 01.

**Pre-analysis snapshot:** `saved_val` copies value every cycle while `analyze_i` is 0, and holds while it is 1.

**Learnt literal**, when value[2:1] = 11, the literal is set to `~saved_val[2:1]` if any of these holds:
- lvl ≠ `cur_lvl_i`,
- the variable is a decision (value[0] = 0),
- `value_i[0]` = 0 (its reason clause lies in another bin).

Otherwise the literal holds. It also holds while `analyze_i` is 1. In all other cases it clears to 00.

**Scan FSM:** IDLE → SCAN → DONE → IDLE.
- IDLE: on `scan_start_i`, clear the index and the max/second registers, then go to SCAN.
- SCAN: visit one variable per cycle. If its learnt literal ≠ 00:
  - lvl > max: second ← max, max ← lvl;
  - else if lvl < max and lvl > second: second ← lvl.
- After index N−1, go to DONE. DONE pulses `scan_done_o` and latches `max_lvl_o`/`bkt_lvl_o`, then returns to IDLE.
- `scan_start_i` outside IDLE is ignored.
- Empty clause: both outputs 0. Single level: `bkt_lvl_o` = 0.

## Timing

- All state is registered. Updates are visible on the cycle after the controlling strobe.
- `conflict_o` and `find_imply_o` are combinational from the registers and `value_i`.
- Scan latency: `scan_start_i` at cycle t gives `scan_done_o` at t+N+1. Outputs hold until the next scan completes.
- Reset values:
  - value 111 (matches the existing per-variable reset);
  - lvl 0, learnt 00;
  - saved phase 1, `saved_val` 000;
  - FSM IDLE, `scan_done_o` 0, `max_lvl_o`/`bkt_lvl_o` 0.
- Reset mid-scan aborts the scan with no done pulse.
- `wr_states_i` during a scan: the load is applied and the scan continues on the loaded learnt values. The controller must not do this.
- Decide and imply on the same variable in the same cycle: the decision wins.
- `dec_idx_i` ≥ N: no effect.

## Structure

- `sat_engine_pkg` holds the value encodings (VAL_FREE, VAL_TRUE, VAL_FALSE, VAL_CONFLICT), the implied-bit position and the FSM state enum.
- Sub-module `var_state_cell` holds one variable's value, lvl, phase, `saved_val` and learnt literal, with per-cell decide/imply/bkt logic. It is generated N times.
- The top level owns the index decode, the conflict OR-reduction and the scan FSM.

## Test plan

- **Reset:** `rst`=0 for 2 cycles → all values 111, all levels 0, `scan_done_o`=0.
- **Decide with phase saving:** `PHASE_SAVE`=1, var 3 previously false then backtracked, decide idx 3 at `cur_lvl_i`=2 → value_o[3] = 010, lvl 2.
- **Imply then conflict:** `value_i` var 1 = 101 with `lvl_i`=2 under `imply_i` → value 101, lvl 2. Then `value_i` var 1 = 111 → `conflict_o`=1.
- **Learnt literals:** vars at levels 1, 3, 3 (decision) conflict-marked at `cur_lvl_i`=3 → `learnt_o` is nonzero for the level-1 var and the level-3 decision var. Then scan → `max_lvl_o`=3, `bkt_lvl_o`=1, done at t+N+1.
- **Backtrack:** `bkt_lvl_i`=1 → vars above level 1 clear to 000, and the learnt var at level 1 flips polarity.
- **Scan edge cases:** empty learnt clause → both levels 0. A second `scan_start_i` issued mid-scan is ignored.
